// File: rtl/fifo_pkg.sv
// Shared definitions for the asymmetric FWFT FIFO and its feeders.
// Contents:
//   FIFO_WR_W / FIFO_RD_W / FIFO_DEPTH : FIFO geometry
//   wr_state_t                         : wide-writer sequencer state
//   wide_beat_t                        : 128-bit beat plus its framing flags
package fifo_pkg;
   localparam int FIFO_WR_W  = 64;
   localparam int FIFO_RD_W  = 128;
   localparam int FIFO_DEPTH = 2048;

   typedef enum logic [1:0] {WR_IDLE, WR_SEND_HI, WR_SEND_LO} wr_state_t;

   typedef struct packed {
      logic [127:0] data;
      logic         last;
      logic         half;
   } wide_beat_t;
endpackage

// File: rtl/fifo_wide_writer.sv
// fifo_wide_writer: splits 128-bit stream beats into two 64-bit FIFO writes,
// upper half first, so the FIFO's 128-bit read word reproduces the beat.
// A half-valid beat has its low word replaced by PAD_WORD, which keeps the
// FIFO word count even and lets the reader drain the final word.
//
// Ports:
//   wr_clk, reset        FIFO write clock; synchronous active-high reset
//   s_valid/s_ready      input beat handshake
//   s_data/s_last/s_half beat payload, packet end, upper-half-only flag
//   fifo_full            registered full flag from the FIFO
//   fifo_wr_en/fifo_din  FIFO write port
//   busy                 holding register occupied
//   pkt_count/word_count packets / 64-bit words written (wrapping)
//   err_half             sticky: s_half accepted without s_last
//   stall_cycles         (WR_STATS_EN only) saturating count of cycles
//                        spent stalled by fifo_full while sending
//
// Optional macro: WR_STATS_EN adds the stall_cycles port and counter.
module fifo_wide_writer
   import fifo_pkg::*;
#(
   parameter int                DIN_W    = 128,
   parameter int                DOUT_W   = 64,
   parameter logic [DOUT_W-1:0] PAD_WORD = '0,
   parameter int                CNT_W    = 16
) (
   input  logic              wr_clk,
   input  logic              reset,
   input  logic              s_valid,
   input  logic [DIN_W-1:0]  s_data,
   input  logic              s_last,
   input  logic              s_half,
   output logic              s_ready,
   input  logic              fifo_full,
   output logic              fifo_wr_en,
   output logic [DOUT_W-1:0] fifo_din,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_count,
   output logic [CNT_W-1:0]  word_count,
   output logic              err_half
`ifdef WR_STATS_EN
   ,output logic [CNT_W-1:0] stall_cycles
`endif
);

   wr_state_t  state_q, state_d;
   wide_beat_t hold_q;
   logic       accept;

   assign accept = s_valid & s_ready;
   assign busy   = (state_q != WR_IDLE);

   // Next state and the combinational write-port mux.
   always_comb begin
      state_d    = state_q;
      s_ready    = 1'b0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      case (state_q)
         WR_IDLE: begin
            s_ready = 1'b1;
            if (s_valid) state_d = WR_SEND_HI;
         end
         WR_SEND_HI: begin
            fifo_din   = hold_q.data[DIN_W-1:DOUT_W];
            fifo_wr_en = ~fifo_full;
            if (!fifo_full) state_d = WR_SEND_LO;
         end
         WR_SEND_LO: begin
            fifo_din   = hold_q.half ? PAD_WORD : hold_q.data[DOUT_W-1:0];
            fifo_wr_en = ~fifo_full;
            // The holding register frees up on this write, so the next beat
            // can land in the same cycle and keep the write port saturated.
            s_ready    = ~fifo_full;
            if (!fifo_full) state_d = s_valid ? WR_SEND_HI : WR_IDLE;
         end
         default: state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         state_q    <= WR_IDLE;
         hold_q     <= '0;
         pkt_count  <= '0;
         word_count <= '0;
         err_half   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            hold_q.data <= s_data;
            hold_q.last <= s_last;
            hold_q.half <= s_half;
            if (s_half && !s_last) err_half <= 1'b1;
         end
         if (fifo_wr_en) word_count <= word_count + CNT_W'(1);
         if (fifo_wr_en && state_q == WR_SEND_LO && hold_q.last)
            pkt_count <= pkt_count + CNT_W'(1);
      end
   end

`ifdef WR_STATS_EN
   always_ff @(posedge wr_clk) begin
      if (reset)
         stall_cycles <= '0;
      else if (busy && fifo_full && stall_cycles != '1)
         stall_cycles <= stall_cycles + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_fifo_wide_writer.sv
// Directed bench for fifo_wide_writer: single beat, back-to-back beats,
// half last beat, stall in SEND_LO, half without last, reset mid-beat.
module tb_fifo_wide_writer;
   localparam int DIN_W  = 128;
   localparam int DOUT_W = 64;
   localparam int CNT_W  = 16;

   logic              wr_clk = 1'b0;
   logic              reset;
   logic              s_valid;
   logic [DIN_W-1:0]  s_data;
   logic              s_last;
   logic              s_half;
   logic              s_ready;
   logic              fifo_full;
   logic              fifo_wr_en;
   logic [DOUT_W-1:0] fifo_din;
   logic              busy;
   logic [CNT_W-1:0]  pkt_count;
   logic [CNT_W-1:0]  word_count;
   logic              err_half;
`ifdef WR_STATS_EN
   logic [CNT_W-1:0]  stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   always #5 wr_clk = ~wr_clk;

   fifo_wide_writer #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .PAD_WORD(64'h0), .CNT_W(CNT_W)) dut (
      .wr_clk(wr_clk), .reset(reset),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_half(s_half),
      .s_ready(s_ready), .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy),
      .pkt_count(pkt_count), .word_count(word_count), .err_half(err_half)
`ifdef WR_STATS_EN
      ,.stall_cycles(stall_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs checked 1 later.
   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   function automatic logic [63:0] bhi(input int k);
      return 64'h1111_0000_0000_0000 + 64'(k);
   endfunction
   function automatic logic [63:0] blo(input int k);
      return 64'h2222_0000_0000_0000 + 64'(k);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_half = 1'b0;
      fifo_full = 1'b0;
      tick(); tick();
      #1;
      chk("rst_ready", s_ready, 1);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_din",   fifo_din, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_pkt",   pkt_count, 0);
      chk("rst_word",  word_count, 0);
      chk("rst_err",   err_half, 0);
`ifdef WR_STATS_EN
      chk("rst_stall", stall_cycles, 0);
`endif
      reset = 1'b0;
      tick();

      // Single full beat.
      s_valid = 1'b1; s_data = 128'h0123456789ABCDEF_FEDCBA9876543210; s_last = 1'b1;
      #1 chk("t1_ready_idle", s_ready, 1);
      tick();
      s_valid = 1'b0;
      #1;
      chk("t1_hi_en",   fifo_wr_en, 1);
      chk("t1_hi_din",  fifo_din, 64'h0123456789ABCDEF);
      chk("t1_hi_busy", busy, 1);
      chk("t1_hi_rdy",  s_ready, 0);
      tick();
      #1;
      chk("t1_lo_en",  fifo_wr_en, 1);
      chk("t1_lo_din", fifo_din, 64'hFEDCBA9876543210);
      chk("t1_lo_rdy", s_ready, 1);
      tick();
      #1;
      chk("t1_idle_en", fifo_wr_en, 0);
      chk("t1_busy",    busy, 0);
      chk("t1_pkt",     pkt_count, 1);
      chk("t1_word",    word_count, 2);

      // Four back-to-back beats; the fourth closes the packet.
      s_valid = 1'b1; s_data = {bhi(0), blo(0)}; s_last = 1'b0;
      #1 chk("t2_ready_idle", s_ready, 1);
      tick();
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("t2_hi_en%0d", k),  fifo_wr_en, 1);
         chk($sformatf("t2_hi_din%0d", k), fifo_din, bhi(k));
         tick();
         if (k < 3) begin
            s_data = {bhi(k + 1), blo(k + 1)};
            s_last = (k + 1 == 3);
         end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
         #1;
         chk($sformatf("t2_lo_en%0d", k),  fifo_wr_en, 1);
         chk($sformatf("t2_lo_din%0d", k), fifo_din, blo(k));
         chk($sformatf("t2_lo_rdy%0d", k), s_ready, 1);
         tick();
      end
      #1;
      chk("t2_idle_en", fifo_wr_en, 0);
      chk("t2_pkt",     pkt_count, 2);
      chk("t2_word",    word_count, 10);

      // Half-valid last beat: low word becomes PAD_WORD (0).
      s_valid = 1'b1; s_data = {64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555};
      s_last = 1'b1; s_half = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0; s_half = 1'b0;
      #1 chk("t3_hi_din", fifo_din, 64'hAAAAAAAAAAAAAAAA);
      tick();
      #1;
      chk("t3_lo_en",  fifo_wr_en, 1);
      chk("t3_lo_din", fifo_din, 64'h0);
      tick();
      #1;
      chk("t3_word", word_count, 12);
      chk("t3_pkt",  pkt_count, 3);
      chk("t3_err",  err_half, 0);

      // Five stall cycles in SEND_LO.
      s_valid = 1'b1; s_data = 128'h0123456789ABCDEF_FEDCBA9876543210; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      #1 chk("t4_hi_en", fifo_wr_en, 1);
      tick();
      fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("t4_stall_en%0d", i),  fifo_wr_en, 0);
         chk($sformatf("t4_stall_din%0d", i), fifo_din, 64'hFEDCBA9876543210);
         chk($sformatf("t4_stall_rdy%0d", i), s_ready, 0);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      chk("t4_resume_en",  fifo_wr_en, 1);
      chk("t4_resume_din", fifo_din, 64'hFEDCBA9876543210);
`ifdef WR_STATS_EN
      chk("t4_stall_cnt", stall_cycles, 5);
`endif
      tick();
      #1;
      chk("t4_busy", busy, 0);
      chk("t4_word", word_count, 14);
      chk("t4_pkt",  pkt_count, 4);

      // s_half without s_last: padded, sticky error, packet count unchanged.
      s_valid = 1'b1; s_data = {64'hCAFEF00DCAFEF00D, 64'h1234567812345678};
      s_last = 1'b0; s_half = 1'b1;
      tick();
      s_valid = 1'b0; s_half = 1'b0;
      #1 chk("t5_hi_din", fifo_din, 64'hCAFEF00DCAFEF00D);
      tick();
      #1 chk("t5_lo_din", fifo_din, 64'h0);
      tick();
      #1;
      chk("t5_err",  err_half, 1);
      chk("t5_pkt",  pkt_count, 4);
      chk("t5_word", word_count, 16);
      tick(); tick();
      #1 chk("t5_err_held", err_half, 1);

      // Reset while in SEND_LO.
      s_valid = 1'b1; s_data = {bhi(7), blo(7)}; s_last = 1'b1;
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      tick();
      reset = 1'b1;
      #1 chk("t6_in_lo", fifo_din, blo(7));
      tick();
      #1;
      chk("t6_busy",  busy, 0);
      chk("t6_ready", s_ready, 1);
      chk("t6_wr_en", fifo_wr_en, 0);
      chk("t6_din",   fifo_din, 0);
      chk("t6_pkt",   pkt_count, 0);
      chk("t6_word",  word_count, 0);
      chk("t6_err",   err_half, 0);
`ifdef WR_STATS_EN
      chk("t6_stall", stall_cycles, 0);
`endif
      reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
